ahbl_arbiter: RTL

AHB-lite N:1 arbiter. It merges N master ports onto one slave port and sits at the top of a slave's fan-in, upstream of splitters or leaf slaves. Arbitration is fixed-priority, lowest index wins. A losing master's address phase is captured into a per-port buffer, and that master is stalled until its transfer is issued and completes.

---
 rtl/ahbl_pkg.sv | 20 ++
 rtl/onehot_mux.sv | 30 +++
 rtl/onehot_priority.sv | 21 ++
 rtl/ahbl_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ahbl_pkg
// Purpose : Shared AHB-lite encodings (HTRANS and HRESP values) used by the
//           AHB-lite interconnect blocks.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/onehot_mux.sv
`default_nettype none
// ============================================================================
// Module  : onehot_mux
// Purpose : AND-OR multiplexer driven by a one-hot select. An all-zero select
//           yields an all-zero output.
// Ports   : sel     - one-hot select (N bits)
//           in_flat - N packed inputs of W bits, input k at [k*W +: W]
//           out     - selected input
// Revision: 1.0 - initial release
// ============================================================================
module onehot_mux #(
  parameter int W = 32,
  parameter int N = 2
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] in_flat,
  output logic [W-1:0]   out
);

  always_comb begin
    out = '0;
    for (int k = 0; k < N; k++) begin
      if (sel[k]) begin
        out = out | in_flat[k*W +: W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/onehot_priority.sv
`default_nettype none
// ============================================================================
// Module  : onehot_priority
// Purpose : Fixed-priority one-hot selector; the lowest set bit of the input
//           wins.
// Ports   : in_vec     - request vector (W bits)
//           out_onehot - one-hot grant, zero when no request is set
// Revision: 1.0 - initial release
// ============================================================================
module onehot_priority #(
  parameter int W = 2
) (
  input  logic [W-1:0] in_vec,
  output logic [W-1:0] out_onehot
);

  // Two's-complement trick: x & -x isolates the lowest set bit.
  assign out_onehot = in_vec & (~in_vec + W'(1));

endmodule
`default_nettype wire

// File: rtl/ahbl_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ahbl_arbiter
// Purpose : AHB-lite N:1 arbiter. Fixed priority (lowest index wins). A
//           losing master's address phase is held in a per-port buffer and
//           that master is stalled until the buffered transfer completes.
//           hmastlock keeps the grant with the locking master.
// Ports   : clk, rst_n                  - clock, async active-low reset
//           src_*  (N_PORTS, flattened)  - master-side AHB-lite ports
//           src_hready_resp / src_hresp  - per-master response
//           src_hrdata                   - slave read data, broadcast
//           dst_*                        - slave-side AHB-lite port
// Revision: 1.0 - initial release
// ============================================================================
module ahbl_arbiter
  import ahbl_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic [N_PORTS-1:0]          src_hready,
  output logic [N_PORTS-1:0]          src_hready_resp,
  output logic [N_PORTS-1:0]          src_hresp,
  input  logic [N_PORTS*W_ADDR-1:0]   src_haddr,
  input  logic [N_PORTS-1:0]          src_hwrite,
  input  logic [N_PORTS*2-1:0]        src_htrans,
  input  logic [N_PORTS*3-1:0]        src_hsize,
  input  logic [N_PORTS*3-1:0]        src_hburst,
  input  logic [N_PORTS*4-1:0]        src_hprot,
  input  logic [N_PORTS-1:0]          src_hmastlock,
  input  logic [N_PORTS*W_DATA-1:0]   src_hwdata,
  output logic [N_PORTS*W_DATA-1:0]   src_hrdata,

  output logic                        dst_hready,
  input  logic                        dst_hready_resp,
  input  logic                        dst_hresp,
  output logic [W_ADDR-1:0]           dst_haddr,
  output logic                        dst_hwrite,
  output logic [1:0]                  dst_htrans,
  output logic [2:0]                  dst_hsize,
  output logic [2:0]                  dst_hburst,
  output logic [3:0]                  dst_hprot,
  output logic                        dst_hmastlock,
  output logic [W_DATA-1:0]           dst_hwdata,
  input  logic [W_DATA-1:0]           dst_hrdata
);

  // Packed address phase: {haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock}
  localparam int AP_W  = W_ADDR + 14;
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS-1:0]      live_req;
  logic [N_PORTS-1:0]      req;
  logic [N_PORTS-1:0]      prio_gnt;
  logic [N_PORTS-1:0]      grant_a;
  logic [N_PORTS-1:0]      mux_sel;
  logic                    grant_any;
  logic [IDX_W-1:0]        grant_idx;
  logic [N_PORTS*AP_W-1:0] live_ap;
  logic [N_PORTS*AP_W-1:0] sel_ap;
  logic [N_PORTS-1:0]      ap_lock;
  logic [AP_W-1:0]         mux_ap;
  logic [1:0]              mux_htrans;

  logic [N_PORTS*AP_W-1:0] buf_q,              buf_d;
  logic [N_PORTS-1:0]      buf_valid_q,        buf_valid_d;
  logic [N_PORTS-1:0]      data_sel_q,         data_sel_d;
  logic [IDX_W-1:0]        lock_owner_q,       lock_owner_d;
  logic                    lock_owner_valid_q, lock_owner_valid_d;

  assign dst_hready = dst_hready_resp;

  // --------------------------------------------------------------------------
  // Per-port request and address-phase selection (buffer overrides live bus)
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
      assign live_ap[i*AP_W +: AP_W] = {src_haddr[i*W_ADDR +: W_ADDR],
                                        src_hwrite[i],
                                        src_htrans[i*2 +: 2],
                                        src_hsize[i*3 +: 3],
                                        src_hburst[i*3 +: 3],
                                        src_hprot[i*4 +: 4],
                                        src_hmastlock[i]};
      // A port with a buffered transfer is stalled, so its live bus is ignored.
      assign live_req[i] = src_htrans[i*2+1] & src_hready[i] & ~buf_valid_q[i];
      assign req[i]      = buf_valid_q[i] | live_req[i];
      assign sel_ap[i*AP_W +: AP_W] = buf_valid_q[i] ? buf_q[i*AP_W +: AP_W]
                                                     : live_ap[i*AP_W +: AP_W];
      assign ap_lock[i]  = sel_ap[i*AP_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Grant
  // --------------------------------------------------------------------------
  onehot_priority #(.W(N_PORTS)) u_prio (
    .in_vec     (req),
    .out_onehot (prio_gnt)
  );

  always_comb begin
    grant_a = prio_gnt;
    // While a lock is held only the owner may be granted, even when idle.
    if (lock_owner_valid_q) begin
      grant_a               = '0;
      grant_a[lock_owner_q] = req[lock_owner_q];
    end
  end

  assign grant_any = |grant_a;

  always_comb begin
    grant_idx = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (grant_a[k]) begin
        grant_idx = IDX_W'(k);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Address phase to slave; with no grant, fields follow port 0 and htrans is
  // forced IDLE.
  // --------------------------------------------------------------------------
  assign mux_sel = grant_any ? grant_a : N_PORTS'(1);

  onehot_mux #(.W(AP_W), .N(N_PORTS)) u_addr_mux (
    .sel     (mux_sel),
    .in_flat (sel_ap),
    .out     (mux_ap)
  );

  assign {dst_haddr, dst_hwrite, mux_htrans, dst_hsize,
          dst_hburst, dst_hprot, dst_hmastlock} = mux_ap;
  assign dst_htrans = grant_any ? mux_htrans : HTRANS_IDLE;

  // --------------------------------------------------------------------------
  // Buffer capture / issue, data-phase owner and lock tracking
  // --------------------------------------------------------------------------
  always_comb begin
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    for (int k = 0; k < N_PORTS; k++) begin
      if (live_req[k] && (!grant_a[k] || !dst_hready_resp)) begin
        buf_valid_d[k]          = 1'b1;
        buf_d[k*AP_W +: AP_W]   = live_ap[k*AP_W +: AP_W];
      end else if (dst_hready_resp && grant_a[k]) begin
        buf_valid_d[k]          = 1'b0;
      end
    end
  end

  assign data_sel_d = dst_hready_resp ? grant_a : data_sel_q;

  always_comb begin
    lock_owner_d       = lock_owner_q;
    lock_owner_valid_d = lock_owner_valid_q;
    if (dst_hready_resp) begin
      if (grant_any && dst_hmastlock) begin
        lock_owner_d       = grant_idx;
        lock_owner_valid_d = 1'b1;
      end else if (lock_owner_valid_q &&
                   (buf_valid_q[lock_owner_q] || src_hready[lock_owner_q]) &&
                   !ap_lock[lock_owner_q]) begin
        // Owner is presenting an unlocked beat (or IDLE): release.
        lock_owner_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q              <= '0;
      buf_valid_q        <= '0;
      data_sel_q         <= '0;
      lock_owner_q       <= '0;
      lock_owner_valid_q <= 1'b0;
    end else begin
      buf_q              <= buf_d;
      buf_valid_q        <= buf_valid_d;
      data_sel_q         <= data_sel_d;
      lock_owner_q       <= lock_owner_d;
      lock_owner_valid_q <= lock_owner_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Responses and data: registered state plus slave inputs only
  // --------------------------------------------------------------------------
  assign src_hready_resp = (data_sel_q & {N_PORTS{dst_hready_resp}}) |
                           (~data_sel_q & ~buf_valid_q);
  assign src_hresp       = data_sel_q & {N_PORTS{dst_hresp}};
  assign src_hrdata      = {N_PORTS{dst_hrdata}};

  onehot_mux #(.W(W_DATA), .N(N_PORTS)) u_wdata_mux (
    .sel     (data_sel_q),
    .in_flat (src_hwdata),
    .out     (dst_hwdata)
  );

endmodule
`default_nettype wire
